// File: rtl/sync_pulse_arbiter_pkg.sv
// sync_arb_pkg: state encoding and default sizing shared by the sync_pulse_arbiter slice.
package sync_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arbState_e;
    localparam int DEF_NREQ = 4;
    localparam int DEF_TAGW = 2;
    localparam int DEF_TMO  = 1024;
endpackage

// File: rtl/sync_pulse_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first pending bit at or after rrPtr with wrap.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int TAGW = 2
) (
    input  logic [NREQ-1:0] pending,
    input  logic [TAGW-1:0] rrPtr,
    output logic            valid,
    output logic [TAGW-1:0] winner
);
    int idx;
    // Scan from the farthest offset down so the nearest pending bit is written last.
    always_comb begin
        valid = |pending;
        winner = '0;
        idx = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(rrPtr) + k) % NREQ;
            if (pending[idx]) winner = TAGW'(idx);
        end
    end
endmodule

// File: rtl/sync_pulse_arbiter.sv
// sync_pulse_arbiter: round-robin funnel of request pulses onto one shared pulse-synchronizer
// channel, with per-requester overflow flags and a sticky ack-timeout flag.
module sync_pulse_arbiter
    import sync_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int TAGW = DEF_TAGW,
    parameter int TMO  = DEF_TMO
) (
    input  logic            sCLK,
    input  logic            sRST,
    input  logic [NREQ-1:0] req,
    output logic            sEN,
    input  logic            sRDY,
    output logic [TAGW-1:0] tag,
    output logic [NREQ-1:0] done,
    output logic            busy,
    output logic [NREQ-1:0] ovf,
    output logic            stall,
    input  logic            clr_err
);
    arbState_e       state, stateNext;
    logic [NREQ-1:0] pending, grantMask;
    logic [TAGW-1:0] rrPtr, winner;
    logic [15:0]     waitCnt;
    logic            pickValid, grant;

    rr_pick #(.NREQ(NREQ), .TAGW(TAGW)) uPick (
        .pending(pending),
        .rrPtr(rrPtr),
        .valid(pickValid),
        .winner(winner)
    );

    always_comb begin
        grant = state == IDLE && sRDY && pickValid;
        grantMask = grant ? NREQ'(1) << winner : '0;
        stateNext = grant ? ISSUE : state == ISSUE ? WAIT : (state == WAIT && !sRDY) ? WAIT : IDLE;
    end

    always_ff @(posedge sCLK) begin
        if (sRST) state <= IDLE;
        else state <= stateNext;
    end

    // A request coinciding with its own grant re-arms pending; only a stacked request is an overflow.
    always_ff @(posedge sCLK) begin
        if (sRST) begin
            pending <= '0;
            rrPtr <= '0;
            tag <= '0;
            waitCnt <= '0;
            ovf <= '0;
            stall <= 1'b0;
        end else begin
            pending <= (pending & ~grantMask) | req;
            ovf <= (clr_err ? '0 : ovf) | (req & pending & ~grantMask);
            stall <= (clr_err ? 1'b0 : stall) | (state == WAIT && waitCnt == 16'(TMO - 1));
            waitCnt <= state != WAIT ? '0 : waitCnt == '1 ? waitCnt : waitCnt + 1'b1;
            if (grant) begin
                tag <= winner;
                rrPtr <= winner == TAGW'(NREQ - 1) ? '0 : winner + 1'b1;
            end
        end
    end

    assign sEN  = !sRST && state == ISSUE;
    assign done = (!sRST && state == WAIT && sRDY) ? NREQ'(1) << tag : '0;
    assign busy = !sRST && (state != IDLE || |pending);
endmodule

// File: tb/tb_sync_pulse_arbiter.sv
// tb_sync_pulse_arbiter: scoreboard bench; expected grant tags are queued with each request
// and checked against sEN/tag and done, with a bench-side model of the channel's sRDY.
`timescale 1ns/1ps
module tb_sync_pulse_arbiter;
    localparam int NREQ = 4;
    localparam int TAGW = 2;
    localparam int TMO  = 8;

    logic            sCLK = 1'b0;
    logic            sRST = 1'b1;
    logic            sRDY = 1'b0;
    logic            clr_err = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic            sEN, busy, stall;
    logic [TAGW-1:0] tag;
    logic [NREQ-1:0] done, ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ackDelay = 4;
    int ackCnt = 0;
    int enCount = 0;
    int lastEnCyc = -1;
    int lastDoneCyc = -1;
    bit holdAck = 1'b0;
    bit sawEn = 1'b0;
    int tagQ[$];
    int doneQ[$];

    sync_pulse_arbiter #(.NREQ(NREQ), .TAGW(TAGW), .TMO(TMO)) dut (
        .sCLK(sCLK),
        .sRST(sRST),
        .req(req),
        .sEN(sEN),
        .sRDY(sRDY),
        .tag(tag),
        .done(done),
        .busy(busy),
        .ovf(ovf),
        .stall(stall),
        .clr_err(clr_err)
    );

    always #5 sCLK = ~sCLK;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor at negedge, then advance one cycle and update the channel's sRDY model.
    task automatic step();
        int e;
        @(negedge sCLK);
        sawEn = sEN;
        if (sEN) begin
            enCount++;
            lastEnCyc = cyc;
            if (tagQ.size() == 0) chk("unexpected_sEN", 1, 0);
            else begin
                e = tagQ.pop_front();
                chk("grant_tag", int'(tag), e);
                doneQ.push_back(1 << e);
            end
        end
        if (done != '0) begin
            lastDoneCyc = cyc;
            if (doneQ.size() == 0) chk("unexpected_done", int'(done), 0);
            else chk("done", int'(done), doneQ.pop_front());
        end
        @(posedge sCLK);
        #1;
        cyc++;
        req = '0;
        if (sawEn) begin
            sRDY = 1'b0;
            ackCnt = ackDelay - 1;
        end else if (!sRDY && !holdAck && !sRST) begin
            ackCnt--;
            if (ackCnt <= 0) sRDY = 1'b1;
        end
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while ((tagQ.size() != 0 || doneQ.size() != 0 || busy) && n < 200) begin
            step();
            n++;
        end
        chk({name, "_drained"}, int'(n < 200), 1);
    endtask

    task automatic doReset();
        sRST = 1'b1;
        sRDY = 1'b0;
        step();
        step();
        sRST = 1'b0;
        sRDY = 1'b1;
        tagQ.delete();
        doneQ.delete();
    endtask

    initial begin
        int t0, en0;
        step();
        step();
        chk("rst_sEN", int'(sEN), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_stall", int'(stall), 0);
        chk("rst_tag", int'(tag), 0);
        sRST = 1'b0;
        sRDY = 1'b1;
        step();

        t0 = cyc;
        req = 4'b0001;
        tagQ.push_back(0);
        waitIdle("single");
        chk("single_sEN_latency", lastEnCyc - t0, 2);
        chk("single_done_cycle", lastDoneCyc - t0, 6);
        chk("single_idle_cycle", cyc - t0, 7);

        doReset();
        req = 4'b1111;
        tagQ = '{0, 1, 2, 3};
        waitIdle("rr_from0");
        req = 4'b0010;
        tagQ.push_back(1);
        waitIdle("rr_set_ptr2");
        req = 4'b1111;
        tagQ = '{2, 3, 0, 1};
        waitIdle("rr_from2");

        en0 = enCount;
        req = 4'b0001;
        tagQ.push_back(0);
        repeat (3) step();
        req = 4'b0010;
        tagQ.push_back(1);
        step();
        req = 4'b0010;
        step();
        chk("ovf_set_early", int'(ovf), 2);
        waitIdle("ovf");
        chk("ovf_transfers", enCount - en0, 2);
        chk("ovf_sticky", int'(ovf), 2);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("ovf_clr", int'(ovf), 0);

        holdAck = 1'b1;
        t0 = cyc;
        en0 = enCount;
        req = 4'b0100;
        tagQ.push_back(2);
        repeat (TMO + 2) step();
        chk("stall_before_tmo", int'(stall), 0);
        step();
        chk("stall_at_tmo", int'(stall), 1);
        repeat (20 - (TMO + 3)) step();
        chk("stall_no_reissue", enCount - en0, 1);
        chk("stall_still_busy", int'(busy), 1);
        sRDY = 1'b1;
        holdAck = 1'b0;
        waitIdle("stall");
        chk("stall_done_cycle", lastDoneCyc - t0, 20);
        chk("stall_sticky", int'(stall), 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("stall_clr", int'(stall), 0);

        holdAck = 1'b1;
        req = 4'b0010;
        tagQ.push_back(1);
        repeat (3) step();
        req = 4'b0100;
        step();
        chk("mid_busy_before_rst", int'(busy), 1);
        sRST = 1'b1;
        req = 4'b1000;
        tagQ.delete();
        doneQ.delete();
        #1;
        chk("mid_rst_sEN", int'(sEN), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        step();
        chk("mid_rst_tag", int'(tag), 0);
        sRST = 1'b0;
        sRDY = 1'b1;
        holdAck = 1'b0;
        #1;
        chk("mid_rst_pending_clr", int'(busy), 0);
        step();
        req = 4'b1000;
        tagQ.push_back(3);
        waitIdle("after_rst_req3");
        chk("after_rst_tag3", int'(tag), 3);

        en0 = enCount;
        req = 4'b0100;
        tagQ.push_back(2);
        step();
        req = 4'b0100;
        tagQ.push_back(2);
        waitIdle("coincident");
        chk("coincident_transfers", enCount - en0, 2);
        chk("coincident_no_ovf", int'(ovf), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
